// File: rtl/l2_arb_pkg.sv
// Shared types for the L2 arbiter: FSM states, requester ids, line width.
// Latency: none (declarations only).
// Backpressure: n/a.
package l2_arb_pkg;

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_ISSUE = 2'd1,
      ST_WAIT  = 2'd2,
      ST_RESP  = 2'd3
   } state_t;

   typedef enum logic {
      REQ_IC = 1'b0,
      REQ_DC = 1'b1
   } req_id_t;

   localparam int unsigned DEFAULT_LINE_SIZE = 64;

   // Cache line width in bits for a line of the given byte size.
   function automatic int unsigned line_bits(input int unsigned line_size);
      return line_size * 8;
   endfunction

   localparam int unsigned LINE_BITS = line_bits(DEFAULT_LINE_SIZE);

endpackage

// File: rtl/rr_arbiter2.sv
// Two-way round-robin grant between I$ and D$ with a last-winner pointer.
// Latency: grant is combinational; pointer updates on the accepting edge.
// Backpressure: pointer only moves when the caller accepts the grant.
module rr_arbiter2
   import l2_arb_pkg::*;
(
   input  logic    clk_i,
   input  logic    rst_ni,
   input  logic    req_ic,
   input  logic    req_dc,
   input  logic    accept,
   output logic    gnt_vld,
   output req_id_t gnt_id
);

   req_id_t last_q;

   // Single requester wins outright; a tie goes to whoever did not win last.
   always_comb begin
      gnt_vld = req_ic | req_dc;
      gnt_id  = REQ_IC;
      if (req_ic && req_dc) begin
         gnt_id = (last_q == REQ_IC) ? REQ_DC : REQ_IC;
      end else if (req_dc) begin
         gnt_id = REQ_DC;
      end
   end

   // Remember the last winner; reset value makes I$ win the first tie.
   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         last_q <= REQ_DC;
      end else if (accept && gnt_vld) begin
         last_q <= gnt_id;
      end
   end

endmodule

// File: rtl/l2_arbiter.sv
// Arbitrates I$ refills and D$ fills/write-backs onto one L2 port, one transaction in flight.
// Latency: 3 cycles from request accept to resp valid with a zero-wait L2.
// Backpressure: requests stall while busy; L2 and requester handshakes hold fields stable.
// Optional watchdog on the L2 response is enabled by defining L2_ARB_TIMEOUT_EN.
module l2_arbiter
   import l2_arb_pkg::*;
#(
   parameter int unsigned ADDR_WIDTH     = 32,
   parameter int unsigned LINE_SIZE      = DEFAULT_LINE_SIZE,
   parameter int unsigned TIMEOUT_CYCLES = 1024
) (
   input  logic                    clk_i,
   input  logic                    rst_ni,
   input  logic                    ic_req_valid_i,
   output logic                    ic_req_ready_o,
   input  logic [ADDR_WIDTH-1:0]   ic_req_addr_i,
   output logic                    ic_resp_valid_o,
   input  logic                    ic_resp_ready_i,
   output logic [LINE_SIZE*8-1:0]  ic_resp_data_o,
   input  logic                    dc_req_valid_i,
   output logic                    dc_req_ready_o,
   input  logic [ADDR_WIDTH-1:0]   dc_req_addr_i,
   input  logic                    dc_req_we_i,
   input  logic [LINE_SIZE*8-1:0]  dc_req_wdata_i,
   output logic                    dc_resp_valid_o,
   input  logic                    dc_resp_ready_i,
   output logic [LINE_SIZE*8-1:0]  dc_resp_data_o,
   output logic                    l2_req_valid_o,
   input  logic                    l2_req_ready_i,
   output logic [ADDR_WIDTH-1:0]   l2_req_addr_o,
   output logic                    l2_req_we_o,
   output logic [LINE_SIZE*8-1:0]  l2_req_wdata_o,
   input  logic                    l2_resp_valid_i,
   output logic                    l2_resp_ready_o,
   input  logic [LINE_SIZE*8-1:0]  l2_resp_data_i
`ifdef L2_ARB_TIMEOUT_EN
   ,
   output logic                    err_timeout_o
`endif
);

   localparam int unsigned OFFSET = $clog2(LINE_SIZE);
   localparam int unsigned LW     = line_bits(LINE_SIZE);

   state_t                  state_q, state_d;
   logic                    run_q;
   logic                    gnt_vld;
   req_id_t                 gnt_id;
   logic                    accept;
   logic                    resp_rdy;
   req_id_t                 owner_q;
   logic [ADDR_WIDTH-1:0]   addr_q;
   logic                    we_q;
   logic [LW-1:0]           wdata_q;
   logic [LW-1:0]           line_q;

`ifdef L2_ARB_TIMEOUT_EN
   localparam int unsigned CW = $clog2(TIMEOUT_CYCLES + 1);
   logic [CW-1:0] cnt_q;
   logic          timeout_hit;
   logic          err_q;
`else
   localparam int unsigned unused_timeout_cycles = TIMEOUT_CYCLES;
`endif

   rr_arbiter2 u_rr (
      .clk_i   (clk_i),
      .rst_ni  (rst_ni),
      .req_ic  (ic_req_valid_i),
      .req_dc  (dc_req_valid_i),
      .accept  (accept),
      .gnt_vld (gnt_vld),
      .gnt_id  (gnt_id)
   );

   // run_q keeps ready low during reset and the first edge after release.
   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) run_q <= 1'b0;
      else         run_q <= 1'b1;
   end

   assign accept   = run_q && (state_q == ST_IDLE) && gnt_vld;
   assign resp_rdy = (owner_q == REQ_IC) ? ic_resp_ready_i : dc_resp_ready_i;

   // State register.
   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) state_q <= ST_IDLE;
      else         state_q <= state_d;
   end

   // Next-state logic for the single outstanding transaction.
   always_comb begin
      state_d = state_q;
`ifdef L2_ARB_TIMEOUT_EN
      timeout_hit = 1'b0;
`endif
      case (state_q)
         ST_IDLE:  if (accept) state_d = ST_ISSUE;
         ST_ISSUE: if (l2_req_ready_i) state_d = ST_WAIT;
         ST_WAIT: begin
            if (l2_resp_valid_i) begin
               state_d = ST_RESP;
            end
`ifdef L2_ARB_TIMEOUT_EN
            else if (cnt_q == CW'(TIMEOUT_CYCLES - 1)) begin
               timeout_hit = 1'b1;
               state_d     = ST_RESP;
            end
`endif
         end
         ST_RESP:  if (resp_rdy) state_d = ST_IDLE;
         default:  state_d = ST_IDLE;
      endcase
   end

   // Latch the granted request (line-aligned) and capture the L2 line.
   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         owner_q <= REQ_IC;
         addr_q  <= '0;
         we_q    <= 1'b0;
         wdata_q <= '0;
         line_q  <= '0;
      end else begin
         if (accept) begin
            owner_q <= gnt_id;
            if (gnt_id == REQ_IC) begin
               addr_q  <= {ic_req_addr_i[ADDR_WIDTH-1:OFFSET], {OFFSET{1'b0}}};
               we_q    <= 1'b0;
               wdata_q <= '0;
            end else begin
               addr_q  <= {dc_req_addr_i[ADDR_WIDTH-1:OFFSET], {OFFSET{1'b0}}};
               we_q    <= dc_req_we_i;
               wdata_q <= dc_req_wdata_i;
            end
         end
         if ((state_q == ST_WAIT) && l2_resp_valid_i) begin
            line_q <= l2_resp_data_i;
         end
`ifdef L2_ARB_TIMEOUT_EN
         if (timeout_hit) begin
            line_q <= '0;
         end
`endif
      end
   end

`ifdef L2_ARB_TIMEOUT_EN
   // Count WAIT cycles from zero and pulse the error on the expiring edge.
   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         cnt_q <= '0;
         err_q <= 1'b0;
      end else begin
         err_q <= timeout_hit;
         if (state_q == ST_ISSUE)     cnt_q <= '0;
         else if (state_q == ST_WAIT) cnt_q <= cnt_q + CW'(1);
      end
   end

   assign err_timeout_o = err_q;
`endif

   assign ic_req_ready_o  = accept && (gnt_id == REQ_IC);
   assign dc_req_ready_o  = accept && (gnt_id == REQ_DC);

   assign l2_req_valid_o  = (state_q == ST_ISSUE);
   assign l2_req_addr_o   = addr_q;
   assign l2_req_we_o     = we_q;
   assign l2_req_wdata_o  = wdata_q;
   assign l2_resp_ready_o = (state_q == ST_WAIT);

   assign ic_resp_valid_o = (state_q == ST_RESP) && (owner_q == REQ_IC);
   assign dc_resp_valid_o = (state_q == ST_RESP) && (owner_q == REQ_DC);
   assign ic_resp_data_o  = ic_resp_valid_o ? line_q : '0;
   // Write-backs carry no data back to the D$.
   assign dc_resp_data_o  = (dc_resp_valid_o && !we_q) ? line_q : '0;

endmodule

// File: tb/tb_l2_arbiter.sv
// Directed self-checking bench for l2_arbiter.
// Latency: checks the 3-cycle accept-to-response path cycle by cycle.
// Backpressure: exercises L2 request stall and requester response stall.
module tb_l2_arbiter;
   import l2_arb_pkg::*;

   localparam int AW = 32;
   localparam int DW = LINE_BITS;

   logic          clk_i = 1'b0;
   logic          rst_ni;
   logic          ic_req_valid_i, ic_req_ready_o;
   logic [AW-1:0] ic_req_addr_i;
   logic          ic_resp_valid_o, ic_resp_ready_i;
   logic [DW-1:0] ic_resp_data_o;
   logic          dc_req_valid_i, dc_req_ready_o;
   logic [AW-1:0] dc_req_addr_i;
   logic          dc_req_we_i;
   logic [DW-1:0] dc_req_wdata_i;
   logic          dc_resp_valid_o, dc_resp_ready_i;
   logic [DW-1:0] dc_resp_data_o;
   logic          l2_req_valid_o, l2_req_ready_i;
   logic [AW-1:0] l2_req_addr_o;
   logic          l2_req_we_o;
   logic [DW-1:0] l2_req_wdata_o;
   logic          l2_resp_valid_i, l2_resp_ready_o;
   logic [DW-1:0] l2_resp_data_i;
`ifdef L2_ARB_TIMEOUT_EN
   logic          err_timeout_o;
`endif

   int checks = 0;
   int errors = 0;

   always #5 clk_i = ~clk_i;

   l2_arbiter #(.ADDR_WIDTH(AW), .LINE_SIZE(DEFAULT_LINE_SIZE), .TIMEOUT_CYCLES(16)) dut (
      .clk_i(clk_i), .rst_ni(rst_ni),
      .ic_req_valid_i(ic_req_valid_i), .ic_req_ready_o(ic_req_ready_o), .ic_req_addr_i(ic_req_addr_i),
      .ic_resp_valid_o(ic_resp_valid_o), .ic_resp_ready_i(ic_resp_ready_i), .ic_resp_data_o(ic_resp_data_o),
      .dc_req_valid_i(dc_req_valid_i), .dc_req_ready_o(dc_req_ready_o), .dc_req_addr_i(dc_req_addr_i),
      .dc_req_we_i(dc_req_we_i), .dc_req_wdata_i(dc_req_wdata_i),
      .dc_resp_valid_o(dc_resp_valid_o), .dc_resp_ready_i(dc_resp_ready_i), .dc_resp_data_o(dc_resp_data_o),
      .l2_req_valid_o(l2_req_valid_o), .l2_req_ready_i(l2_req_ready_i), .l2_req_addr_o(l2_req_addr_o),
      .l2_req_we_o(l2_req_we_o), .l2_req_wdata_o(l2_req_wdata_o),
      .l2_resp_valid_i(l2_resp_valid_i), .l2_resp_ready_o(l2_resp_ready_o), .l2_resp_data_i(l2_resp_data_i)
`ifdef L2_ARB_TIMEOUT_EN
      , .err_timeout_o(err_timeout_o)
`endif
   );

   // One clock: let the edge happen, then sample on the falling edge.
   task automatic tick();
      @(posedge clk_i);
      @(negedge clk_i);
   endtask

   task automatic do_reset();
      rst_ni = 1'b0;
      @(negedge clk_i);
      @(negedge clk_i);
      rst_ni = 1'b1;
      @(negedge clk_i);
   endtask

   // From ISSUE with l2_req_ready_i high: return data, take the response, back to IDLE.
   task automatic serve(input logic [DW-1:0] d, output logic [DW-1:0] got);
      tick();
      l2_resp_valid_i = 1'b1;
      l2_resp_data_i  = d;
      tick();
      l2_resp_valid_i = 1'b0;
      got             = ic_resp_data_o | dc_resp_data_o;
      ic_resp_ready_i = 1'b1;
      dc_resp_ready_i = 1'b1;
      tick();
      ic_resp_ready_i = 1'b0;
      dc_resp_ready_i = 1'b0;
   endtask

   task automatic test_reset();
      ic_req_valid_i = 1'b1;
      dc_req_valid_i = 1'b1;
      @(negedge clk_i);
      @(negedge clk_i);
      checks++;
      if ({ic_req_ready_o, dc_req_ready_o, l2_req_valid_o, l2_resp_ready_o, ic_resp_valid_o, dc_resp_valid_o, l2_req_we_o} !== 7'b0) begin
         errors++;
         $display("FAIL reset_handshakes: got %b expected 0000000",
                  {ic_req_ready_o, dc_req_ready_o, l2_req_valid_o, l2_resp_ready_o, ic_resp_valid_o, dc_resp_valid_o, l2_req_we_o});
      end
      checks++;
      if ((l2_req_addr_o !== '0) || (l2_req_wdata_o !== '0) || (ic_resp_data_o !== '0) || (dc_resp_data_o !== '0)) begin
         errors++;
         $display("FAIL reset_data: addr %h wdata_or %b ic_or %b dc_or %b expected all zero",
                  l2_req_addr_o, |l2_req_wdata_o, |ic_resp_data_o, |dc_resp_data_o);
      end
      ic_req_valid_i = 1'b0;
      dc_req_valid_i = 1'b0;
      rst_ni = 1'b1;
      @(negedge clk_i);
   endtask

   task automatic test_ic_read();
      logic [DW-1:0] pat;
      pat = {64{8'hA5}};
      ic_req_valid_i = 1'b1;
      ic_req_addr_i  = 32'h0000_1234;
      l2_req_ready_i = 1'b1;
      #1;
      checks++;
      if ({ic_req_ready_o, dc_req_ready_o} !== 2'b10) begin
         errors++;
         $display("FAIL ic_read_grant: got %b expected 10", {ic_req_ready_o, dc_req_ready_o});
      end
      tick();
      ic_req_valid_i = 1'b0;
      checks++;
      if ({l2_req_valid_o, l2_req_we_o, ic_resp_valid_o} !== 3'b100 || l2_req_addr_o !== 32'h0000_1200) begin
         errors++;
         $display("FAIL ic_read_issue: valid/we/resp %b addr %h expected 100 addr 00001200",
                  {l2_req_valid_o, l2_req_we_o, ic_resp_valid_o}, l2_req_addr_o);
      end
      tick();
      checks++;
      if ({l2_resp_ready_o, l2_req_valid_o, ic_resp_valid_o} !== 3'b100) begin
         errors++;
         $display("FAIL ic_read_wait: got %b expected 100", {l2_resp_ready_o, l2_req_valid_o, ic_resp_valid_o});
      end
      l2_resp_valid_i = 1'b1;
      l2_resp_data_i  = pat;
      tick();
      l2_resp_valid_i = 1'b0;
      checks++;
      if ({ic_resp_valid_o, dc_resp_valid_o} !== 2'b10 || ic_resp_data_o !== pat) begin
         errors++;
         $display("FAIL ic_read_resp: valids %b data %h expected 10 data %h",
                  {ic_resp_valid_o, dc_resp_valid_o}, ic_resp_data_o, pat);
      end
      ic_resp_ready_i = 1'b1;
      tick();
      ic_resp_ready_i = 1'b0;
      checks++;
      if (ic_resp_valid_o !== 1'b0) begin
         errors++;
         $display("FAIL ic_read_done: resp_valid %b expected 0", ic_resp_valid_o);
      end
   endtask

   task automatic test_tie();
      logic [DW-1:0] got;
      do_reset();
      l2_req_ready_i = 1'b1;
      ic_req_valid_i = 1'b1;
      ic_req_addr_i  = 32'h0000_0100;
      dc_req_valid_i = 1'b1;
      dc_req_addr_i  = 32'h0000_0240;
      dc_req_we_i    = 1'b0;
      #1;
      checks++;
      if ({ic_req_ready_o, dc_req_ready_o} !== 2'b10) begin
         errors++;
         $display("FAIL tie1_grant: got %b expected 10", {ic_req_ready_o, dc_req_ready_o});
      end
      tick();
      ic_req_valid_i = 1'b0;
      #1;
      checks++;
      if (l2_req_addr_o !== 32'h0000_0100 || dc_req_ready_o !== 1'b0) begin
         errors++;
         $display("FAIL tie1_issue: addr %h dc_ready %b expected 00000100 0", l2_req_addr_o, dc_req_ready_o);
      end
      serve({16{32'h1111_0001}}, got);
      // Second tie: I$ asks again while D$ still waits; D$ must win now.
      ic_req_valid_i = 1'b1;
      ic_req_addr_i  = 32'h0000_0140;
      #1;
      checks++;
      if ({ic_req_ready_o, dc_req_ready_o} !== 2'b01) begin
         errors++;
         $display("FAIL tie2_grant: got %b expected 01", {ic_req_ready_o, dc_req_ready_o});
      end
      tick();
      dc_req_valid_i = 1'b0;
      checks++;
      if (l2_req_addr_o !== 32'h0000_0240) begin
         errors++;
         $display("FAIL tie2_issue: addr %h expected 00000240", l2_req_addr_o);
      end
      serve({16{32'h2222_0002}}, got);
      checks++;
      if (got !== {16{32'h2222_0002}}) begin
         errors++;
         $display("FAIL tie2_dc_data: got %h expected %h", got, {16{32'h2222_0002}});
      end
      #1;
      checks++;
      if ({ic_req_ready_o, dc_req_ready_o} !== 2'b10) begin
         errors++;
         $display("FAIL tie3_grant: got %b expected 10", {ic_req_ready_o, dc_req_ready_o});
      end
      tick();
      ic_req_valid_i = 1'b0;
      checks++;
      if (l2_req_addr_o !== 32'h0000_0140) begin
         errors++;
         $display("FAIL tie3_issue: addr %h expected 00000140", l2_req_addr_o);
      end
      serve({16{32'h3333_0003}}, got);
   endtask

   task automatic test_writeback();
      logic [DW-1:0] wb;
      wb = {16{32'hDEAD_BEEF}};
      l2_req_ready_i = 1'b1;
      dc_req_valid_i = 1'b1;
      dc_req_addr_i  = 32'h8000_0040;
      dc_req_we_i    = 1'b1;
      dc_req_wdata_i = wb;
      #1;
      checks++;
      if ({ic_req_ready_o, dc_req_ready_o} !== 2'b01) begin
         errors++;
         $display("FAIL wb_grant: got %b expected 01", {ic_req_ready_o, dc_req_ready_o});
      end
      tick();
      dc_req_valid_i = 1'b0;
      dc_req_we_i    = 1'b0;
      dc_req_wdata_i = '0;
      checks++;
      if (l2_req_we_o !== 1'b1 || l2_req_wdata_o !== wb || l2_req_addr_o !== 32'h8000_0040) begin
         errors++;
         $display("FAIL wb_issue: we %b addr %h wdata %h expected 1 80000040 %h", l2_req_we_o, l2_req_addr_o, l2_req_wdata_o, wb);
      end
      tick();
      l2_resp_valid_i = 1'b1;
      l2_resp_data_i  = {DW{1'b1}};
      tick();
      l2_resp_valid_i = 1'b0;
      checks++;
      if ({dc_resp_valid_o, ic_resp_valid_o} !== 2'b10 || dc_resp_data_o !== '0) begin
         errors++;
         $display("FAIL wb_resp: valids %b data %h expected 10 and zero data", {dc_resp_valid_o, ic_resp_valid_o}, dc_resp_data_o);
      end
      dc_resp_ready_i = 1'b1;
      tick();
      dc_resp_ready_i = 1'b0;
      checks++;
      if (dc_resp_valid_o !== 1'b0) begin
         errors++;
         $display("FAIL wb_done: resp_valid %b expected 0", dc_resp_valid_o);
      end
   endtask

   task automatic test_stall();
      logic [DW-1:0] pat;
      pat = {32{16'h5A3C}};
      l2_req_ready_i = 1'b0;
      ic_req_valid_i = 1'b1;
      ic_req_addr_i  = 32'h0000_2FC4;
      tick();
      ic_req_valid_i = 1'b0;
      // D$ request shows up while busy and is withdrawn before any grant.
      dc_req_valid_i = 1'b1;
      dc_req_addr_i  = 32'h0000_0300;
      for (int i = 0; i < 5; i++) begin
         #1;
         checks++;
         if (l2_req_valid_o !== 1'b1 || l2_req_addr_o !== 32'h0000_2FC0 || l2_req_we_o !== 1'b0 || dc_req_ready_o !== 1'b0) begin
            errors++;
            $display("FAIL stall_issue_hold[%0d]: valid %b addr %h we %b dc_ready %b expected 1 00002fc0 0 0",
                     i, l2_req_valid_o, l2_req_addr_o, l2_req_we_o, dc_req_ready_o);
         end
         tick();
      end
      dc_req_valid_i = 1'b0;
      l2_req_ready_i = 1'b1;
      tick();
      l2_resp_valid_i = 1'b1;
      l2_resp_data_i  = pat;
      tick();
      l2_resp_valid_i = 1'b0;
      l2_resp_data_i  = '0;
      for (int i = 0; i < 4; i++) begin
         checks++;
         if (ic_resp_valid_o !== 1'b1 || ic_resp_data_o !== pat) begin
            errors++;
            $display("FAIL stall_resp_hold[%0d]: valid %b data %h expected 1 %h", i, ic_resp_valid_o, ic_resp_data_o, pat);
         end
         tick();
      end
      ic_resp_ready_i = 1'b1;
      tick();
      ic_resp_ready_i = 1'b0;
      for (int i = 0; i < 3; i++) begin
         checks++;
         if ({l2_req_valid_o, ic_resp_valid_o, dc_resp_valid_o} !== 3'b000) begin
            errors++;
            $display("FAIL stall_single_txn[%0d]: got %b expected 000", i, {l2_req_valid_o, ic_resp_valid_o, dc_resp_valid_o});
         end
         tick();
      end
   endtask

   task automatic test_reset_mid();
      l2_req_ready_i = 1'b1;
      ic_req_valid_i = 1'b1;
      ic_req_addr_i  = 32'h0000_4000;
      tick();
      ic_req_valid_i = 1'b0;
      tick();
      checks++;
      if (l2_resp_ready_o !== 1'b1) begin
         errors++;
         $display("FAIL rst_mid_in_wait: l2_resp_ready %b expected 1", l2_resp_ready_o);
      end
      rst_ni = 1'b0;
      #1;
      checks++;
      if ({l2_resp_ready_o, l2_req_valid_o, ic_resp_valid_o, ic_req_ready_o} !== 4'b0 || l2_req_addr_o !== '0) begin
         errors++;
         $display("FAIL rst_mid_outputs: got %b addr %h expected 0000 addr 0",
                  {l2_resp_ready_o, l2_req_valid_o, ic_resp_valid_o, ic_req_ready_o}, l2_req_addr_o);
      end
      @(negedge clk_i);
      rst_ni = 1'b1;
      @(negedge clk_i);
      l2_resp_valid_i = 1'b1;
      l2_resp_data_i  = {64{8'hA5}};
      for (int i = 0; i < 3; i++) begin
         checks++;
         if ({ic_resp_valid_o, dc_resp_valid_o, l2_resp_ready_o, l2_req_valid_o} !== 4'b0) begin
            errors++;
            $display("FAIL rst_mid_no_resp[%0d]: got %b expected 0000", i, {ic_resp_valid_o, dc_resp_valid_o, l2_resp_ready_o, l2_req_valid_o});
         end
         tick();
      end
      l2_resp_valid_i = 1'b0;
   endtask

`ifdef L2_ARB_TIMEOUT_EN
   task automatic test_timeout();
      l2_req_ready_i = 1'b1;
      ic_req_valid_i = 1'b1;
      ic_req_addr_i  = 32'h0000_5000;
      l2_resp_data_i = {DW{1'b1}};
      tick();
      ic_req_valid_i = 1'b0;
      tick();
      for (int i = 0; i < 16; i++) begin
         checks++;
         if ({err_timeout_o, l2_resp_ready_o, ic_resp_valid_o} !== 3'b010) begin
            errors++;
            $display("FAIL timeout_wait[%0d]: err/ready/resp %b expected 010", i, {err_timeout_o, l2_resp_ready_o, ic_resp_valid_o});
         end
         tick();
      end
      checks++;
      if ({err_timeout_o, ic_resp_valid_o} !== 2'b11 || ic_resp_data_o !== '0) begin
         errors++;
         $display("FAIL timeout_fire: err/resp %b data %h expected 11 and zero data", {err_timeout_o, ic_resp_valid_o}, ic_resp_data_o);
      end
      ic_resp_ready_i = 1'b1;
      tick();
      ic_resp_ready_i = 1'b0;
      checks++;
      if ({err_timeout_o, ic_resp_valid_o, l2_req_valid_o} !== 3'b000) begin
         errors++;
         $display("FAIL timeout_idle: err/resp/req %b expected 000", {err_timeout_o, ic_resp_valid_o, l2_req_valid_o});
      end
   endtask
`endif

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      rst_ni          = 1'b0;
      ic_req_valid_i  = 1'b0;
      ic_req_addr_i   = '0;
      ic_resp_ready_i = 1'b0;
      dc_req_valid_i  = 1'b0;
      dc_req_addr_i   = '0;
      dc_req_we_i     = 1'b0;
      dc_req_wdata_i  = '0;
      dc_resp_ready_i = 1'b0;
      l2_req_ready_i  = 1'b0;
      l2_resp_valid_i = 1'b0;
      l2_resp_data_i  = '0;
      test_reset();
      test_ic_read();
      test_tie();
      test_writeback();
      test_stall();
      test_reset_mid();
`ifdef L2_ARB_TIMEOUT_EN
      test_timeout();
`endif
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
